pipe_collision_score: RTL and testbench

//  Game-control stage wrapped around the pipe shifter. Consumes its shift/counter

---
 rtl/pipe_collision_score.sv | 146 ++++++++++++++
 tb/tb_pipe_collision_score.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_collision_score.sv
// Game-control stage for the scrolling-pipe game.
// Runs the IDLE/PLAY/DEAD state machine, picks a pseudo-random gap row
// for each pipe pass, detects bird collisions with the pipe or the ground,
// and keeps a saturating two-digit BCD score. Its gameover output freezes
// the pipe shifter, and pipe_rst restarts the shifter on a new game.
module pipe_collision_score #(
    parameter int COLS     = 16,
    parameter int ROWS     = 16,
    parameter int GAP_H    = 4,
    parameter int BIRD_COL = 3,
    parameter int GAP_INIT = 6,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  bird_y,
    input  logic [31:0] shift,
    input  logic [31:0] counter,
    output logic        gameover,
    output logic        pipe_rst,
    output logic        pipe_valid,
    output logic [3:0]  pipe_col,
    output logic [3:0]  gap_top,
    output logic [7:0]  score_bcd,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } state_t;

    state_t      state_q;
    logic [7:0]  lfsr;
    logic [31:0] counter_q;

    logic        hit;
    logic        pass;
    logic        in_gap;
    logic        lfsr_fb;
    logic [7:0]  gap_sum;
    logic [3:0]  gap_next;
    logic [7:0]  score_next;
    logic [4:0]  gap_end;

    assign state = state_q;

    // Pipe position on screen: the shifter offset counts columns from the right edge
    always_comb begin
        pipe_valid = (shift <= 32'(COLS - 1));
        pipe_col   = 4'(COLS - 1) - shift[3:0];
    end

    // Collision and pass detection; a hit only counts while actually playing
    always_comb begin
        gap_end = {1'b0, gap_top} + 5'(GAP_H);
        in_gap  = (bird_y >= gap_top) && ({1'b0, bird_y} < gap_end);
        hit     = (state_q == PLAY) &&
                  ((pipe_valid && (pipe_col == 4'(BIRD_COL)) && !in_gap) ||
                   (bird_y == 4'(ROWS - 1)));
        pass    = (counter != counter_q);
    end

    // Next gap row drawn from the LFSR, and the saturating BCD increment of the score
    always_comb begin
        lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        gap_sum  = ({4'b0000, lfsr[3:0]} % 8'(ROWS - GAP_H - 1)) + 8'd1;
        gap_next = gap_sum[3:0];
        if (score_bcd == 8'h99) begin
            score_next = 8'h99;
        end else if (score_bcd[3:0] == 4'd9) begin
            score_next = {score_bcd[7:4] + 4'd1, 4'd0};
        end else begin
            score_next = {score_bcd[7:4], score_bcd[3:0] + 4'd1};
        end
    end

    // Free-running LFSR so the gap sequence depends on how long each state lasted
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Delayed copy of the shifter pass count; any difference marks a completed pass
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= counter;
        end else begin
            counter_q <= counter;
        end
    end

    // Game state machine with registered gameover, restart pulse, score and gap row
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gameover  <= 1'b1;
            pipe_rst  <= 1'b0;
            gap_top   <= 4'(GAP_INIT);
            score_bcd <= 8'h00;
        end else begin
            pipe_rst <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= PLAY;
                        gameover <= 1'b0;
                    end else begin
                        gameover <= 1'b1;
                    end
                end
                PLAY: begin
                    if (hit) begin
                        state_q  <= DEAD;
                        gameover <= 1'b1;
                    end else begin
                        gameover <= 1'b0;
                        if (pass) begin
                            score_bcd <= score_next;
                            gap_top   <= gap_next;
                        end
                    end
                end
                DEAD: begin
                    gameover <= 1'b1;
                    if (start) begin
                        state_q   <= IDLE;
                        pipe_rst  <= 1'b1;
                        score_bcd <= 8'h00;
                        gap_top   <= 4'(GAP_INIT);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gameover <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_collision_score.sv
// Directed testbench for pipe_collision_score: reset, start handling,
// pipe/ground collisions, gap boundaries, BCD scoring with saturation,
// hit-over-pass priority, restart pulse and mid-game reset.
module tb_pipe_collision_score;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  bird_y;
    logic [31:0] shift;
    logic [31:0] counter;
    logic        gameover;
    logic        pipe_rst;
    logic        pipe_valid;
    logic [3:0]  pipe_col;
    logic [3:0]  gap_top;
    logic [7:0]  score_bcd;
    logic [1:0]  state;

    int vectors;
    int miscompares;
    logic [3:0] saved_gap;

    pipe_collision_score dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bird_y     (bird_y),
        .shift      (shift),
        .counter    (counter),
        .gameover   (gameover),
        .pipe_rst   (pipe_rst),
        .pipe_valid (pipe_valid),
        .pipe_col   (pipe_col),
        .gap_top    (gap_top),
        .score_bcd  (score_bcd),
        .state      (state)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle away from the edge
    task automatic apply_step();
        @(posedge clk);
        #1;
    endtask

    // One shifter pass: bump the counter for a single cycle
    task automatic apply_pass();
        counter = counter + 32'd1;
        apply_step();
    endtask

    // Compare one observed value against its expected value
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Two start pulses from DEAD: back to IDLE with restart pulse, then into PLAY
    task automatic apply_restart();
        start = 1'b1;
        apply_step();
        start = 1'b0;
        check_output("restart_pipe_rst", 32'(pipe_rst), 32'd1);
        check_output("restart_state", 32'(state), 32'd0);
        check_output("restart_score", 32'(score_bcd), 32'h00);
        check_output("restart_gap", 32'(gap_top), 32'd6);
        start = 1'b1;
        apply_step();
        start = 1'b0;
        check_output("restart_pulse_end", 32'(pipe_rst), 32'd0);
        check_output("restart_play", 32'(state), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        start   = 1'b0;
        bird_y  = 4'd7;
        shift   = 32'd16;
        counter = 32'd0;

        // Reset held two cycles
        apply_step();
        apply_step();
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_gameover", 32'(gameover), 32'd1);
        check_output("reset_score", 32'(score_bcd), 32'h00);
        check_output("reset_gap", 32'(gap_top), 32'd6);
        check_output("reset_pipe_rst", 32'(pipe_rst), 32'd0);
        rst = 1'b0;
        apply_step();
        check_output("idle_hold", 32'(state), 32'd0);

        // Combinational pipe position
        shift = 32'd16;
        #1;
        check_output("valid_off_screen", 32'(pipe_valid), 32'd0);
        shift = 32'd0;
        #1;
        check_output("valid_shift0", 32'(pipe_valid), 32'd1);
        check_output("col_shift0", 32'(pipe_col), 32'd15);
        shift = 32'd12;
        #1;
        check_output("valid_shift12", 32'(pipe_valid), 32'd1);
        check_output("col_shift12", 32'(pipe_col), 32'd3);
        shift = 32'd16;

        // Start into PLAY, second start ignored
        start = 1'b1;
        apply_step();
        start = 1'b0;
        check_output("start_state", 32'(state), 32'd1);
        check_output("start_gameover", 32'(gameover), 32'd0);
        start = 1'b1;
        apply_step();
        start = 1'b0;
        check_output("start_in_play", 32'(state), 32'd1);

        // Gap rows 6..9 are open at the bird column
        shift  = 32'd12;
        bird_y = 4'd9;
        apply_step();
        check_output("gap_bottom_edge", 32'(state), 32'd1);
        bird_y = 4'd6;
        apply_step();
        check_output("gap_top_edge", 32'(state), 32'd1);
        bird_y = 4'd10;
        apply_step();
        check_output("below_gap_hit", 32'(state), 32'd2);
        check_output("below_gap_gameover", 32'(gameover), 32'd1);

        bird_y = 4'd7;
        shift  = 32'd16;
        apply_restart();

        // Above the gap at the bird column
        shift  = 32'd12;
        bird_y = 4'd2;
        apply_step();
        check_output("above_gap_hit", 32'(state), 32'd2);
        check_output("above_gap_gameover", 32'(gameover), 32'd1);
        bird_y = 4'd7;
        shift  = 32'd16;
        apply_restart();

        // Scoring: nine passes, then the tens carry
        for (int i = 0; i < 9; i++) begin
            apply_pass();
            check_output("gap_in_range", 32'((gap_top >= 4'd1) && (gap_top <= 4'd11)), 32'd1);
        end
        check_output("score_09", 32'(score_bcd), 32'h09);
        apply_pass();
        check_output("score_10", 32'(score_bcd), 32'h10);
        saved_gap = gap_top;
        apply_step();
        check_output("gap_stable_no_pass", 32'(gap_top), 32'(saved_gap));
        check_output("score_stable_no_pass", 32'(score_bcd), 32'h10);
        for (int i = 0; i < 89; i++) begin
            apply_pass();
        end
        check_output("score_99", 32'(score_bcd), 32'h99);
        apply_pass();
        check_output("score_saturate", 32'(score_bcd), 32'h99);
        check_output("gap_in_range_late", 32'((gap_top >= 4'd1) && (gap_top <= 4'd11)), 32'd1);

        // Ground hit with no pipe on screen
        bird_y = 4'd15;
        apply_step();
        check_output("ground_hit", 32'(state), 32'd2);
        check_output("ground_score", 32'(score_bcd), 32'h99);

        // Pass while DEAD leaves score and gap alone
        saved_gap = gap_top;
        apply_pass();
        check_output("dead_pass_score", 32'(score_bcd), 32'h99);
        check_output("dead_pass_gap", 32'(gap_top), 32'(saved_gap));
        check_output("dead_pass_state", 32'(state), 32'd2);

        bird_y = 4'd7;
        apply_restart();

        // Simultaneous pass and hit: hit wins
        apply_pass();
        check_output("score_01", 32'(score_bcd), 32'h01);
        saved_gap = gap_top;
        bird_y = 4'd15;
        apply_pass();
        check_output("pass_hit_state", 32'(state), 32'd2);
        check_output("pass_hit_score", 32'(score_bcd), 32'h01);
        check_output("pass_hit_gap", 32'(gap_top), 32'(saved_gap));

        bird_y = 4'd7;
        apply_restart();

        // Reset in the middle of a game
        apply_pass();
        check_output("pre_reset_score", 32'(score_bcd), 32'h01);
        rst = 1'b1;
        apply_step();
        rst = 1'b0;
        check_output("midgame_state", 32'(state), 32'd0);
        check_output("midgame_score", 32'(score_bcd), 32'h00);
        check_output("midgame_gap", 32'(gap_top), 32'd6);
        check_output("midgame_pipe_rst", 32'(pipe_rst), 32'd0);
        check_output("midgame_gameover", 32'(gameover), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
